instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 152 +++++++++++++++
 tb/tb_instr_fetch.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: next-PC select, imem req/ack, decode queue.
// Optional misaligned-PC fault when FETCH_ALIGN_CHECK_EN is defined.
module instr_fetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetIF_n,
  input  logic [31:0] pc_in,
  output logic [31:0] next_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE  = (PW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
`ifdef FETCH_ALIGN_CHECK_EN
    , FAULT
`endif
  } state_t;

  state_t state;

  logic [31:0] addr_q [DEPTH];
  logic [31:0] word_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   cnt_after;
  logic          push;
  logic          pop;

  assign instr_valid = count != '0;
  assign pop = instr_valid && instr_ready;
  assign push = (state == REQ) && imem_ack && !redirect;
  assign cnt_after = count + ONE - (pop ? ONE : '0);

  assign instr    = instr_valid ? word_q[rd_ptr] : '0;
  assign instr_pc = instr_valid ? addr_q[rd_ptr] : '0;

  always_comb begin
    next_pc = pc_in;
    if (redirect)
      next_pc = redirect_pc;
    else if (state == REQ && imem_ack)
      next_pc = imem_addr + 32'd4;
  end

  // Storage needs no reset: the head is gated by instr_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= imem_addr;
      word_q[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetIF_n) begin
    if (!resetIF_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + ONE;
      else if (!push && pop)
        count <= count - ONE;
    end
  end

  always_ff @(posedge clk or negedge resetIF_n) begin
    if (!resetIF_n) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!redirect && count < FULL) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (pc_in[1:0] != 2'b00) begin
              fetch_fault <= 1'b1;
              state       <= FAULT;
            end else begin
              imem_req  <= 1'b1;
              imem_addr <= pc_in;
              state     <= REQ;
            end
`else
            imem_req  <= 1'b1;
            imem_addr <= {pc_in[31:2], 2'b00};
            state     <= REQ;
`endif
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (!redirect && cnt_after < FULL) begin
              imem_addr <= imem_addr + 32'd4;
            end else begin
              imem_req <= 1'b0;
              state    <= IDLE;
            end
          end else if (redirect) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        FAULT: begin
          if (redirect) begin
            fetch_fault <= 1'b0;
            state       <= IDLE;
          end
        end
`endif
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table, corner sequences, random vs model.
// Exercises the fault path when FETCH_ALIGN_CHECK_EN is defined.
module tb_instr_fetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic [31:0] boot_pc = 32'h1000;
  logic [31:0] next_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        fetch_fault;

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return a ^ 32'hA5C3_0F1E ^ {a[15:0], a[31:16]};
  endfunction

  assign imem_rdata = imem_ack ? hash(imem_addr) : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= boot_pc;
    else        pc <= next_pc;
  end

  instr_fetch #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .resetIF_n(rst_n),
    .pc_in(pc),
    .next_pc(next_pc),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .fetch_fault(fetch_fault)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic r,
                       input logic rd, input logic [31:0] rpc);
    imem_ack    = a;
    instr_ready = r;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] bp);
    boot_pc = bp;
    drive(1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] npc;
  } vec_t;

  vec_t vt [6];

  logic [31:0] mq [$];
  logic [31:0] fa;
  logic [31:0] exp_np;
  logic [31:0] rpc;
  logic        stale;
  logic        a, r, rd, p;
  int          delivered;

  initial begin
    vt[0] = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h1000};
    vt[1] = '{1'b1, 1'b1, 1'b1, 32'h1000, 1'b0, 32'h0,    32'h1004};
    vt[2] = '{1'b1, 1'b1, 1'b1, 32'h1004, 1'b1, 32'h1000, 32'h1008};
    vt[3] = '{1'b1, 1'b1, 1'b1, 32'h1008, 1'b1, 32'h1004, 32'h100C};
    vt[4] = '{1'b1, 1'b1, 1'b1, 32'h100C, 1'b1, 32'h1008, 32'h1010};
    vt[5] = '{1'b1, 1'b1, 1'b1, 32'h1010, 1'b1, 32'h100C, 32'h1014};

    // streaming from reset, one instruction per cycle
    do_reset(32'h1000);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].ack, vt[i].rdy, 1'b0, '0);
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vt[i].req});
      chk($sformatf("v%0d_addr", i), imem_addr, vt[i].addr);
      chk($sformatf("v%0d_vld", i), {31'b0, instr_valid},
          {31'b0, vt[i].vld});
      chk($sformatf("v%0d_ipc", i), instr_pc, vt[i].ipc);
      chk($sformatf("v%0d_instr", i), instr,
          vt[i].vld ? hash(vt[i].ipc) : 32'h0);
      chk($sformatf("v%0d_npc", i), next_pc, vt[i].npc);
      tick();
    end

    // fill queue, single pop, resume two edges later
    do_reset(32'h1000);
    drive(1'b1, 1'b0, 1'b0, '0);
    repeat (7) tick();
    chk("full_req", {31'b0, imem_req}, 32'h0);
    chk("full_head", instr_pc, 32'h1000);
    chk("full_pc", pc, 32'h1010);
    drive(1'b1, 1'b1, 1'b0, '0);
    tick();
    drive(1'b1, 1'b0, 1'b0, '0);
    #1;
    chk("pop1_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("resume_req", {31'b0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'h1010);
    drive(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drain%0d", i), instr_pc, 32'h1004 + 32'(4 * i));
      tick();
    end
    chk("drained", {31'b0, instr_valid}, 32'h0);

    // redirect while request outstanding -> discard
    do_reset(32'h1000);
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h2000);
    #1;
    chk("disc_npc", next_pc, 32'h2000);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    repeat (2) tick();
    chk("disc_req", {31'b0, imem_req}, 32'h1);
    chk("disc_addr", imem_addr, 32'h1000);
    drive(1'b1, 1'b0, 1'b0, '0);
    #1;
    chk("disc_ack_npc", next_pc, 32'h2000);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("disc_drop_vld", {31'b0, instr_valid}, 32'h0);
    chk("disc_drop_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("disc_new_addr", imem_addr, 32'h2000);
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    chk("disc_push", instr_pc, 32'h2000);

    // redirect + ack + pop at count 2
    do_reset(32'h1000);
    drive(1'b1, 1'b0, 1'b0, '0);
    repeat (3) tick();
    drive(1'b1, 1'b1, 1'b1, 32'h3000);
    #1;
    chk("rap_npc", next_pc, 32'h3000);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("rap_vld", {31'b0, instr_valid}, 32'h0);
    chk("rap_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("rap_addr", imem_addr, 32'h3000);

    // address wrap
    do_reset(32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 1'b0, 1'b0, '0);
    #1;
    chk("wrap_npc", next_pc, 32'h0);
    tick();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_head", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_fault", {31'b0, fetch_fault}, 32'h0);

    // asynchronous reset mid-request
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_vld", {31'b0, instr_valid}, 32'h0);

    // misaligned redirect target
    do_reset(32'h1000);
    drive(1'b0, 1'b0, 1'b1, 32'h1002);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_fault", {31'b0, fetch_fault}, 32'h1);
    chk("mis_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("mis_hold", next_pc, 32'h1002);
    chk("mis_fault2", {31'b0, fetch_fault}, 32'h1);
    drive(1'b0, 1'b0, 1'b1, 32'h1004);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("mis_clear", {31'b0, fetch_fault}, 32'h0);
    tick();
    chk("mis_resume", imem_addr, 32'h1004);
    chk("mis_resume_req", {31'b0, imem_req}, 32'h1);
`else
    chk("mis_addr", imem_addr, 32'h1000);
    chk("mis_fault", {31'b0, fetch_fault}, 32'h0);
`endif

    // randomized run against a transaction-level model
    do_reset(32'h1000);
    mq.delete();
    fa = 32'h1000;
    stale = 1'b0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_vld", {31'b0, instr_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("rnd_ipc", instr_pc, mq[0]);
        chk("rnd_instr", instr, hash(mq[0]));
      end
      if (imem_req && !stale)
        chk("rnd_addr", imem_addr, fa);
      if (mq.size() == DEPTH)
        chk("rnd_full_req", {31'b0, imem_req}, 32'h0);
      a  = $urandom_range(0, 99) < 55;
      r  = $urandom_range(0, 99) < 60;
      rd = $urandom_range(0, 99) < 6;
      rpc = {$urandom(), 2'b00} >> 2 << 2;
      if ($urandom_range(0, 7) == 0)
        rpc = 32'hFFFF_FFF8;
      drive(a, r, rd, rpc);
      #1;
      if (rd)
        exp_np = rpc;
      else if (imem_req && a && !stale)
        exp_np = fa + 32'd4;
      else
        exp_np = pc;
      chk("rnd_npc", next_pc, exp_np);
      p = (mq.size() != 0) && r;
      if (rd) begin
        mq.delete();
        if (imem_req && !a)
          stale = 1'b1;
        else if (imem_req && a)
          stale = 1'b0;
        fa = rpc;
      end else begin
        if (p) begin
          void'(mq.pop_front());
          delivered++;
        end
        if (imem_req && a) begin
          if (stale) begin
            stale = 1'b0;
          end else begin
            mq.push_back(fa);
            fa = fa + 32'd4;
          end
        end
      end
      tick();
    end
    chk("rnd_progress", {31'b0, delivered > 300}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
